// File: rtl/dsp_chain_collector.sv
// Collection stage for the dsp_chain_no_en MAC chain: tracks sample validity
// through the chain's fixed latency, formats each valid 32-bit result to 16 bits
// (round, shift, saturate) and buffers it in a first-word-fall-through FIFO.
// The chain cannot stall, so results arriving while the FIFO is full are dropped
// and flagged on the sticky overflow output.
module dsp_chain_collector #(
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 16,
    parameter int LATENCY = 7,
    parameter int SHIFT   = 0,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        p_in,
    input  logic                     flush,
    input  logic                     clear_ovf,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Half-LSB of the shifted result; rounds half toward +infinity.
    localparam logic [DATA_W:0] RND = (SHIFT > 0) ? ((DATA_W + 1)'(1) << RND_SH) : '0;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [LATENCY-1:0]       v;
    logic                     wr;
    logic                     pop;
    logic                     full;
    logic                     push;
    logic                     drop;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [OUT_W-1:0]         mem [DEPTH];
    logic signed [DATA_W:0]   rnd;
    logic signed [DATA_W:0]   shd;
    logic [DATA_W-OUT_W+1:0]  hi;
    logic [OUT_W-1:0]         fmt;

    // Round, arithmetic shift and saturate the chain result.
    always_comb begin
        rnd = $signed({p_in[DATA_W-1], p_in}) + $signed(RND);
        shd = rnd >>> SHIFT;
        // In range when every bit above the output sign bit matches it.
        hi  = shd[DATA_W:OUT_W-1];
        if ((&hi) || !(|hi)) begin
            fmt = shd[OUT_W-1:0];
        end else if (shd[DATA_W]) begin
            fmt = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            fmt = {1'b0, {(OUT_W - 1){1'b1}}};
        end
    end

    // FIFO handshake decode and FWFT output.
    always_comb begin
        wr        = v[LATENCY-1];
        out_valid = (level != '0);
        full      = (level == FULL_LVL);
        pop       = out_valid & out_ready;
        push      = wr & (~full | pop);
        // A write discarded by flush is not a drop.
        drop      = wr & full & ~pop & ~flush;
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Valid pipe matching the chain latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            v[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
            end
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle beats clear_ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // FIFO storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= fmt;
        end
    end

endmodule
